// File: rtl/joy_poll_scheduler_pkg.sv
// Shared definitions for the joystick poll scheduler: FSM states, frame
// field positions and direction flag bit indices.
package joy_poll_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        XFER    = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4
    } pollState_t;

    localparam int FRAME_W  = 40;
    localparam int AXIS_W   = 10;
    localparam int BTN_W    = 3;
    localparam int DIR_W    = 4;

    localparam int X_LO_MSB = 39;
    localparam int X_LO_LSB = 32;
    localparam int X_HI_MSB = 25;
    localparam int X_HI_LSB = 24;
    localparam int Y_LO_MSB = 23;
    localparam int Y_LO_LSB = 16;
    localparam int Y_HI_MSB = 9;
    localparam int Y_HI_LSB = 8;
    localparam int BTN_MSB  = 2;
    localparam int BTN_LSB  = 0;

    // Direction vector is ordered {UP, DOWN, LEFT, RIGHT}
    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

endpackage

// File: rtl/joy_frame_decode.sv
// Combinational field extraction from the raw SPI frame plus threshold
// classification of the currently latched X/Y position.
module joy_frame_decode
    import joy_poll_scheduler_pkg::*;
#(
    parameter int LO_TH = 300,
    parameter int HI_TH = 700
) (
    input  logic [FRAME_W-1:0] frame,
    input  logic [AXIS_W-1:0]  xLatched,
    input  logic [AXIS_W-1:0]  yLatched,
    output logic [AXIS_W-1:0]  xNew,
    output logic [AXIS_W-1:0]  yNew,
    output logic [BTN_W-1:0]   btnNew,
    output logic [DIR_W-1:0]   dirFlags
);

    localparam logic [AXIS_W-1:0] LO_LIMIT = AXIS_W'(LO_TH);
    localparam logic [AXIS_W-1:0] HI_LIMIT = AXIS_W'(HI_TH);

    // Frame bytes that carry no joystick information
    logic unusedFrameBits;
    assign unusedFrameBits = ^{frame[31:26], frame[15:10], frame[7:3]};

    assign xNew   = {frame[X_HI_MSB:X_HI_LSB], frame[X_LO_MSB:X_LO_LSB]};
    assign yNew   = {frame[Y_HI_MSB:Y_HI_LSB], frame[Y_LO_MSB:Y_LO_LSB]};
    assign btnNew = frame[BTN_MSB:BTN_LSB];

    always_comb begin
        dirFlags            = '0;
        dirFlags[DIR_UP]    = (yLatched > HI_LIMIT);
        dirFlags[DIR_DOWN]  = (yLatched < LO_LIMIT);
        dirFlags[DIR_LEFT]  = (xLatched < LO_LIMIT);
        dirFlags[DIR_RIGHT] = (xLatched > HI_LIMIT);
    end

endmodule

// File: rtl/joy_poll_scheduler.sv
// Periodically requests a joystick frame from the SPI read controller,
// supervises the transfer and publishes the decoded position and buttons.
module joy_poll_scheduler
    import joy_poll_scheduler_pkg::*;
#(
    parameter int POLL_DIV = 1000000,
    parameter int TIMEOUT  = 200000,
    parameter int LO_TH    = 300,
    parameter int HI_TH    = 700
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               ss,
    input  logic [FRAME_W-1:0] din,
    output logic               snd_rec,
    output logic [AXIS_W-1:0]  x,
    output logic [AXIS_W-1:0]  y,
    output logic [BTN_W-1:0]   btn,
    output logic [DIR_W-1:0]   dir,
    output logic [BTN_W-1:0]   btn_press,
    output logic               valid,
    output logic               timeout_err,
    output logic               poll_busy
);

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [AXIS_W-1:0] AXIS_MID = AXIS_W'(512);

    pollState_t       state;
    logic [PW-1:0]    pollCnt;
    logic [TW-1:0]    toCnt;
    logic             relCnt;
    logic             pollTick;
    logic [AXIS_W-1:0] xNew;
    logic [AXIS_W-1:0] yNew;
    logic [BTN_W-1:0]  btnNew;
    logic [DIR_W-1:0]  dirFlags;

    joy_frame_decode #(
        .LO_TH (LO_TH),
        .HI_TH (HI_TH)
    ) frameDecode (
        .frame    (din),
        .xLatched (x),
        .yLatched (y),
        .xNew     (xNew),
        .yNew     (yNew),
        .btnNew   (btnNew),
        .dirFlags (dirFlags)
    );

    assign pollTick = en && (pollCnt == POLL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pollCnt <= '0;
        end else if (!en || pollTick) begin
            pollCnt <= '0;
        end else begin
            pollCnt <= pollCnt + PW'(1);
        end
    end

    // Ticks seen outside IDLE, or while the read controller is still busy, are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            toCnt       <= '0;
            relCnt      <= 1'b0;
            snd_rec     <= 1'b0;
            x           <= AXIS_MID;
            y           <= AXIS_MID;
            btn         <= '0;
            dir         <= '0;
            btn_press   <= '0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            poll_busy   <= 1'b0;
        end else begin
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            btn_press   <= '0;
            dir         <= dirFlags;
            case (state)
                IDLE: begin
                    if (pollTick && ss) begin
                        state     <= REQ;
                        toCnt     <= '0;
                        snd_rec   <= 1'b1;
                        poll_busy <= 1'b1;
                    end
                end
                REQ, XFER: begin
                    if (toCnt == TO_LAST) begin
                        state       <= RELEASE;
                        relCnt      <= 1'b0;
                        snd_rec     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        toCnt <= toCnt + TW'(1);
                        if (state == REQ && !ss) begin
                            state <= XFER;
                        end else if (state == XFER && ss) begin
                            state     <= CAPTURE;
                            x         <= xNew;
                            y         <= yNew;
                            btn       <= btnNew;
                            btn_press <= btnNew & ~btn;
                            valid     <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    state   <= RELEASE;
                    relCnt  <= 1'b0;
                    snd_rec <= 1'b0;
                end
                RELEASE: begin
                    if (relCnt) begin
                        state     <= IDLE;
                        poll_busy <= 1'b0;
                    end else begin
                        relCnt <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    snd_rec   <= 1'b0;
                    poll_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
